// File: rtl/ram_bus_bridge_pkg.sv
// Shared types for the CPU/loader to on-chip RAM bridge.
package ram_bus_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    ACK,
    RELEASE
  } state_e;

  // Loader words always fill both byte lanes.
  localparam logic [1:0] LDR_BYTEENA = 2'b11;

endpackage

// File: rtl/ram_bus_bridge.sv
// Arbitrates CPU word/byte accesses and a streaming loader onto a single-port
// RAM with one-cycle registered read; the loader wins whenever the bridge is idle.
module ram_bus_bridge
  import ram_bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,

  input  logic                  cpu_sel,
  input  logic                  cpu_rd_ena,
  input  logic                  cpu_wr_ena,
  input  logic [1:0]            cpu_byte_ena,
  input  logic [31:0]           cpu_address,
  input  logic [15:0]           cpu_wr_data,
  output logic [15:0]           cpu_rd_data,
  output logic                  cpu_data_ack,

  input  logic                  ldr_start,
  input  logic                  ldr_valid,
  input  logic [15:0]           ldr_data,
  output logic                  ldr_ready,
  output logic [ADDR_WIDTH-2:0] ldr_addr,

  output logic                  ram_wren,
  output logic [1:0]            ram_byteena,
  output logic [ADDR_WIDTH-2:0] ram_address,
  output logic [15:0]           ram_data,
  input  logic [15:0]           ram_q
);

  localparam int WAW = ADDR_WIDTH - 1;

  state_e         state;
  logic [WAW-1:0] addr_q;
  logic           idle;
  logic           cpu_req;
  logic           ldr_xfer;
  logic           cpu_take;

  // NOTE: reset_n is folded into the idle term so ldr_ready and ram_wren stay
  // low for the whole reset window, not just after the first clock edge.
  always_comb begin
    idle     = reset_n && (state == IDLE);
    cpu_req  = cpu_sel && (cpu_rd_ena || cpu_wr_ena);
    ldr_xfer = idle && ldr_valid;
    cpu_take = idle && !ldr_valid && cpu_req;
  end

  assign ldr_ready = ldr_xfer;

  // NOTE: every output gets a default before the priority chain; without it a
  // path that skips an assignment would infer a latch.
  always_comb begin
    ram_wren    = 1'b0;
    ram_byteena = cpu_byte_ena;
    ram_address = addr_q;
    ram_data    = cpu_wr_data;
    if (ldr_xfer) begin
      ram_wren    = 1'b1;
      ram_byteena = LDR_BYTEENA;
      ram_address = ldr_addr;
      ram_data    = ldr_data;
    end else if (cpu_take) begin
      ram_address = cpu_address[ADDR_WIDTH-1:1];
      ram_wren    = cpu_wr_ena;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cpu_data_ack <= 1'b0;
      cpu_rd_data  <= '0;
      addr_q       <= '0;
      ldr_addr     <= '0;
    end else begin
      cpu_data_ack <= 1'b0;

      // A start coinciding with a transfer still writes the old address.
      if (ldr_start) begin
        ldr_addr <= '0;
      end else if (ldr_xfer) begin
        ldr_addr <= ldr_addr + WAW'(1);
      end

      case (state)
        IDLE: begin
          if (cpu_take) begin
            addr_q <= cpu_address[ADDR_WIDTH-1:1];
            if (cpu_wr_ena) begin
              state        <= ACK;
              cpu_data_ack <= 1'b1;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          cpu_rd_data  <= ram_q;
          cpu_data_ack <= 1'b1;
          state        <= RD_CAP;
        end
        RD_CAP, ACK: state <= RELEASE;
        // Hold off until the CPU drops its strobes so one request gives one ack.
        RELEASE: begin
          if (!cpu_rd_ena && !cpu_wr_ena) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_bus_bridge.md
RAM_BUS_BRIDGE -- requirements
Module: ram_bus_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, giving the RAM byte-address width (4 KB).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clock (in, 1, rising-edge), reset_n (in, 1, async assert, active-low).
REQ-003 SHALL have CPU-side ports:
- cpu_sel (in, 1): address window hit from top-level decode.
- cpu_rd_ena (in, 1): read request.
- cpu_wr_ena (in, 1): write request.
- cpu_byte_ena (in, 2): byte lanes; [1] = D15:8.
- cpu_address (in, 32): byte address, held stable until ack.
- cpu_wr_data (in, 16): write data.
- cpu_rd_data (out, 16): registered read data.
- cpu_data_ack (out, 1): one-cycle completion pulse.
REQ-004 SHALL have loader ports:
- ldr_start (in, 1): pulse that clears the load address.
- ldr_valid (in, 1): word available.
- ldr_data (in, 16): word to write.
- ldr_ready (out, 1): word accepted this cycle.
- ldr_addr (out, ADDR_WIDTH-1): next word address.
REQ-005 SHALL have RAM-side ports, matching onchip_ram with 1-cycle registered read:
- ram_wren (out, 1).
- ram_byteena (out, 2).
- ram_address (out, ADDR_WIDTH-1).
- ram_data (out, 16).
- ram_q (in, 16).

Function
REQ-006 SHALL implement FSM states IDLE, RD_WAIT, RD_CAP, ACK, RELEASE.
REQ-007 In IDLE, a CPU request (cpu_sel & (cpu_rd_ena | cpu_wr_ena)) SHALL drive ram_address = cpu_address[ADDR_WIDTH-1:1] combinationally in the same cycle.
REQ-008 CPU write: in IDLE, ram_wren=1, ram_byteena=cpu_byte_ena, ram_data=cpu_wr_data for exactly one cycle; then ACK; cpu_data_ack high on cycle N+1 (N = request-sample cycle).
REQ-009 CPU read: IDLE(N) -> RD_WAIT(N+1) -> RD_CAP(N+2).
- ram_address is held from the captured address in RD_WAIT and RD_CAP.
- cpu_rd_data <= ram_q at the end of RD_WAIT.
- cpu_data_ack high on cycle N+2.
REQ-010 cpu_data_ack SHALL be a single-cycle pulse; the FSM SHALL then enter RELEASE and remain there until cpu_rd_ena=0 and cpu_wr_ena=0, then return to IDLE.
REQ-011 cpu_rd_ena and cpu_wr_ena both high SHALL be treated as a write.
REQ-012 A write with cpu_byte_ena=00 SHALL assert ram_wren with ram_byteena=00 and still acknowledge.
REQ-013 Requests with cpu_sel=0 SHALL be ignored (no RAM access, no ack).
REQ-014 Loader handshake: ldr_ready = (state==IDLE) & ldr_valid, combinational. A transfer occurs when ldr_valid & ldr_ready.
REQ-015 On a loader transfer: ram_wren=1, ram_byteena=11, ram_address=ldr_addr, ram_data=ldr_data; ldr_addr increments by 1 after the transfer.
REQ-016 Loader SHALL have priority over a simultaneous CPU request in IDLE; the CPU request is serviced in the first IDLE cycle with ldr_valid=0.
REQ-017 ldr_addr SHALL wrap from all-ones to 0.
REQ-018 ldr_start SHALL set ldr_addr to 0 next cycle. If ldr_start coincides with a transfer, the write uses the old address and ldr_addr becomes 0.
REQ-019 Outside REQ-008 and REQ-015 write cycles, ram_wren SHALL be 0. When idle with no request, ram_address and ram_data SHALL be don't-care.

Reset
REQ-020 On reset_n=0, regardless of cycle in progress:
- FSM -> IDLE.
- cpu_data_ack=0, cpu_rd_data=0.
- ldr_addr=0, ldr_ready=0, ram_wren=0.
REQ-021 A read or write aborted by reset SHALL produce no ack after reset release; the CPU must re-issue.

Structure
REQ-022 Package ram_bus_bridge_pkg SHALL hold the FSM state enum and the loader byte-enable constant (2'b11).
REQ-023 No sub-module SHALL be used; onchip_ram is instantiated by the parent, not inside this block.

Verification
REQ-024 Write 0xBEEF at 0x010 with byte_ena=11, then read 0x010 -> write ack on N+1, read ack on N+2, cpu_rd_data=0xBEEF.
REQ-025 Write 0x1234 with byte_ena=01 over 0xBEEF -> readback 0xBE34; byte_ena=00 -> data unchanged, ack still pulses.
REQ-026 ldr_valid and CPU read in the same IDLE cycle -> loader write at ldr_addr first, CPU ack delayed accordingly; exactly one ack.
REQ-027 CPU holds cpu_rd_ena for 5 cycles after ack -> one ack only, FSM stays in RELEASE, no repeated RAM access.
REQ-028 2048 loader words with ADDR_WIDTH=12 -> ldr_addr wraps to 0; ldr_start mid-stream resets ldr_addr to 0.
REQ-029 reset_n low during RD_WAIT -> no ack, all outputs at reset values, next request serviced normally.
